// File: rtl/pwm_audio_out.sv
// pwm_audio_out: turns 8-bit offset-binary audio samples into a single-bit PWM
// stream for the board audio amp. One sample (plus attenuation) is latched per
// PWM period, scaled about mid-scale by an arithmetic right shift, and compared
// against a free-running period counter. An IDLE/RUN/STOP machine makes sure
// that every started period is completed, so enabling and disabling never
// produce runt pulses.
//
// Optional feature: define PWM_CENTER_ALIGNED_EN for center-aligned PWM. The
// period doubles to 2^(WIDTH+1) clocks and the pulse is centred on the middle
// of the period.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   en          run request (level)
//   sample      unsigned offset-binary sample, mid-scale = 2^(WIDTH-1)
//   atten       right-shift attenuation, 0 = full volume
//   pwm_out     registered PWM audio bit
//   aud_sd      registered amp enable, high while RUN or STOP
//   sample_tick registered one-cycle pulse marking a sample/atten latch
module pwm_audio_out #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ATTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  input  logic [ATTW-1:0]  atten,
  output logic             pwm_out,
  output logic             aud_sd,
  output logic             sample_tick
);

`ifdef PWM_CENTER_ALIGNED_EN
  localparam int unsigned CW = WIDTH + 1;
`else
  localparam int unsigned CW = WIDTH;
`endif
  localparam int unsigned SW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MID = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] duty, duty_n;
  logic             pwm_n, aud_sd_n, latch;
  logic             wrap;

  logic signed [SW-1:0] s_off, s_shr;
  logic [WIDTH-1:0]     scaled;
  logic [WIDTH-1:0]     tri_pos;

  // Volume scaling about mid-scale; only consumed on latch edges.
  always_comb begin
    s_off = $signed({1'b0, sample}) - $signed({1'b0, MID});
    s_shr = s_off >>> atten;
    if (32'(atten) >= WIDTH) begin
      // Shifting a negative value this far would leave -1, not 0.
      scaled = MID;
    end else begin
      // Result is always in range, so modular addition is exact.
      scaled = MID + s_shr[WIDTH-1:0];
    end
  end

  assign wrap = (cnt == {CW{1'b1}});

  // Next-state, counter, duty latch and output decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    duty_n   = duty;
    latch    = 1'b0;
    pwm_n    = 1'b0;
    aud_sd_n = 1'b0;
    tri_pos  = '0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) begin
          state_n = RUN;
          latch   = 1'b1;
        end
      end
      RUN: begin
        cnt_n = cnt + CW'(1);
        if (wrap) begin
          if (en) begin
            latch = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (!en) begin
          state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt + CW'(1);
        if (wrap) begin
          if (en) begin
            // A rising en on the wrap edge behaves exactly like a RUN wrap.
            state_n = RUN;
            latch   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (en) begin
          // Resume without relatching; the current period keeps its duty.
          state_n = RUN;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (state_n == IDLE) begin
      cnt_n = '0;
    end
    if (latch) begin
      cnt_n  = '0;
      duty_n = scaled;
    end

    // Outputs are computed from next-cycle values so the registered pwm_out
    // lines up with cycle index k = cnt.
`ifdef PWM_CENTER_ALIGNED_EN
    tri_pos = cnt_n[CW-1] ? cnt_n[WIDTH-1:0] : ~cnt_n[WIDTH-1:0];
`else
    tri_pos = cnt_n[WIDTH-1:0];
`endif
    aud_sd_n = (state_n != IDLE);
    pwm_n    = aud_sd_n && (tri_pos < duty_n);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      duty        <= '0;
      pwm_out     <= 1'b0;
      aud_sd      <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      duty        <= duty_n;
      pwm_out     <= pwm_n;
      aud_sd      <= aud_sd_n;
      sample_tick <= latch;
    end
  end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Sample-to-speaker back end of the synth audio path: consumes the 8-bit unsigned sine samples produced by the note/synth controller and turns them into a single-bit PWM stream for the board audio output.
- Latches one sample per PWM period and applies a shift-based volume attenuation about mid-scale.
- Runs an IDLE/RUN/STOP state machine so enabling and disabling never produce runt pulses.
- Drives the audio-amp shutdown line and emits a per-period sample strobe back upstream.

Parameters:
- WIDTH, 8, sample width in bits; base PWM period is 2^WIDTH clocks.
- ATTW, 3, width of the attenuation input.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  run request; level-sensitive.
- sample  input  WIDTH  unsigned offset-binary sample; mid-scale = 2^(WIDTH-1).
- atten  input  ATTW  right-shift attenuation; 0 = full volume.
- pwm_out  output  1  PWM audio bit, registered.
- aud_sd  output  1  amp enable, high when state is RUN or STOP; registered.
- sample_tick  output  1  one-cycle pulse; a new sample/atten pair was latched.

Behaviour:
- Reset: async. Forces state=IDLE, cnt=0, duty=0, pwm_out=0, aud_sd=0, sample_tick=0, all immediately. Applies the same way mid-period; no completion of the current period.
- Scaling, computed at latch time only:
  - s = sample − 2^(WIDTH-1), signed WIDTH+1 bits.
  - duty = 2^(WIDTH-1) + (s >>> atten), arithmetic shift.
  - atten ≥ WIDTH gives duty = 2^(WIDTH-1).
  - Result always lies in 0..2^WIDTH−1; no saturation needed.
- Counter: cnt is WIDTH bits, increments every cycle in RUN/STOP. Wrap edge is the edge where cnt == 2^WIDTH−1.
- PWM: period cycle index k = 0..2^WIDTH−1, starting the cycle after a latch edge.
  - pwm_out = 1 in cycles k < duty, so it is high for exactly duty clocks per period.
  - duty=0 gives constant low; duty=2^WIDTH−1 gives one low clock per period (never 100%).
- State IDLE: cnt held 0, pwm_out=0, aud_sd=0.
  - en=1 at an edge → RUN. Same edge: latch duty/atten, cnt<=0, sample_tick<=1.
- State RUN:
  - en=0 before wrap → STOP; the current period continues unchanged.
  - At the wrap edge with en=1 → latch new duty, cnt<=0, sample_tick<=1, stay in RUN.
  - At the wrap edge with en=0 → IDLE.
- State STOP: finishes the period.
  - en=1 again before wrap → RUN, with no extra latch.
  - Wrap edge with en=0 → IDLE, cnt=0, pwm_out=0, aud_sd=0 next cycle.
- Simultaneous events:
  - en falling on the wrap edge → IDLE; no latch, no sample_tick.
  - en rising on the same edge STOP wraps → treated as RUN wrap; latch and tick.
- Latching: sample/atten are sampled only on latch edges. Changes between latches have no effect.
- sample_tick: exactly one cycle wide, high in cycle k=0 of each period. Period = 2^WIDTH clocks, i.e. 390.625 kHz at 100 MHz with WIDTH=8.
- Latency: pwm_out reflects the new duty starting at k=0, one clock after the latch edge.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined:
  - Period becomes 2^(WIDTH+1) clocks; k = 0..2^(WIDTH+1)−1.
  - Triangle t = 2^WIDTH−1−k for k < 2^WIDTH, else k−2^WIDTH.
  - pwm_out = 1 when t < duty, giving one contiguous 2·duty-clock pulse centred on k = 2^WIDTH.
  - Wrap/latch/STOP rules apply at the end of the doubled period; sample_tick once per doubled period.
- Undefined: edge-aligned behaviour as above.

Test Plan:
- Reset mid-RUN (en=1, sample=200, assert rst at k=50) → pwm_out, aud_sd, sample_tick all 0 combinationally; IDLE after release with en=0.
- en=1, sample=64, atten=0 → sample_tick at k=0; pwm_out high for exactly 64 of 256 clocks every period; aud_sd=1.
- Scaling at atten=1: sample=255 → 191 high clocks; sample=0 → 64 high clocks. atten=7, sample=255 → 128 high clocks.
- Boundary duties: sample=0 → pwm_out never high; sample=255, atten=0 → 255 high, 1 low per period.
- en dropped at k=100 of a 128-duty period → full 128-clock pulse completes, IDLE after the wrap, no tick. Separately, en re-raised at k=200 → RUN, next tick at k=0 of the following period.
- Under PWM_CENTER_ALIGNED_EN, sample=10 → 512-clock period; pwm_out high for k=246..265 (20 clocks); one tick per 512 clocks.
